// File: rtl/riscv_inst_encoder.sv
// riscv_inst_encoder: range-checks instruction descriptions and emits RV32I words with sequential byte addresses.
module riscv_inst_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_kind,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7b5,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [7:0]  err_cnt
);
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic [31:0] pc_q, pc_d;
   logic        err_q, err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        legal, accept, load, rej, shift;
   logic        imm12_ok, imm13_ok, imm21_ok, sh_ok;
   logic [31:0] enc;

   // A value fits an N-bit signed field when every bit above the field's sign bit matches it.
   assign imm12_ok = &in_imm[31:11] | ~|in_imm[31:11];
   assign imm13_ok = &in_imm[31:12] | ~|in_imm[31:12];
   assign imm21_ok = &in_imm[31:20] | ~|in_imm[31:20];
   assign sh_ok    = ~|in_imm[31:5];
   assign shift    = in_funct3 == 3'b001 || in_funct3 == 3'b101;

   always_comb begin
      legal = 1'b0;
      enc   = '0;
      case (in_kind)
         4'd0: begin
            legal = 1'b1;
            enc   = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         end
         4'd1: begin
            legal = shift ? sh_ok : imm12_ok;
            enc   = {shift ? {1'b0, in_funct7b5, 5'b0, in_imm[4:0]} : in_imm[11:0],
                     in_rs1, in_funct3, in_rd, 7'b0010011};
         end
         4'd2: begin
            legal = imm12_ok;
            enc   = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
         end
         4'd3: begin
            legal = imm12_ok;
            enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
         end
         4'd4, 4'd5: begin
            legal = imm13_ok & ~in_imm[0];
            enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b00, in_kind[0],
                     in_imm[4:1], in_imm[11], 7'b1100011};
         end
         4'd6: begin
            legal = imm21_ok & ~in_imm[0];
            enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
         end
         4'd7: begin
            legal = imm12_ok;
            enc   = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
         end
         4'd8: begin
            legal = ~|in_imm[11:0];
            enc   = {in_imm[31:12], in_rd, 7'b0110111};
         end
         default: begin
            legal = 1'b0;
            enc   = '0;
         end
      endcase
   end

   assign in_ready = rst_n & ~clear & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign load     = accept & legal;
   assign rej      = accept & ~legal;

   // clear blocks acceptance through in_ready, so load/rej are already low during clear.
   always_comb begin
      out_valid_d = clear ? 1'b0 : load ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
      out_instr_d = load ? enc : out_instr_q;
      out_addr_d  = load ? pc_q : out_addr_q;
      pc_d        = clear ? '0 : load ? pc_q + 32'd4 : pc_q;
      err_d       = clear ? 1'b0 : err_q | rej;
      err_cnt_d   = clear ? '0 : (rej && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= '0;
         pc_q        <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         pc_q        <= pc_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = out_addr_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_riscv_inst_encoder.sv
// tb_riscv_inst_encoder: directed and randomized checks against a transaction-level reference model.
module tb_riscv_inst_encoder;
   logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, err, in_funct7b5 = 1'b0;
   logic [3:0]  in_kind = '0;
   logic [2:0]  in_funct3 = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0, out_instr, out_addr;
   logic [7:0]  err_cnt;
   int          total = 0, bad = 0;
   logic        m_valid = 1'b0, m_err = 1'b0;
   logic [31:0] m_instr = '0, m_addr = '0, m_pc = '0;
   int          m_cnt = 0;

   riscv_inst_encoder dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .err(err),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference encoder: legality from signed integer ranges, fields placed arithmetically.
   function automatic void ref_enc(input int k, input int f3, input int b5, input int rd,
                                   input int rs1, input int rs2, input int imm,
                                   output bit ok, output logic [31:0] w);
      logic [31:0] u;
      bit          sh;
      u  = imm;
      sh = (f3 == 1 || f3 == 5);
      ok = 1'b0;
      w  = '0;
      case (k)
         0: begin ok = 1; w = (b5 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33; end
         1: begin
            ok = sh ? (imm >= 0 && imm <= 31) : (imm >= -2048 && imm <= 2047);
            w  = ((sh ? ((b5 << 10) | (u & 31)) : (u & 'hFFF)) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
         end
         2: begin ok = imm >= -2048 && imm <= 2047; w = ((u & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03; end
         3: begin
            ok = imm >= -2048 && imm <= 2047;
            w  = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((u & 31) << 7) | 'h23;
         end
         4, 5: begin
            ok = imm >= -4096 && imm <= 4094 && imm % 2 == 0;
            w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15) |
                 ((k - 4) << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 'h63;
         end
         6: begin
            ok = imm >= -(1 << 20) && imm <= (1 << 20) - 2 && imm % 2 == 0;
            w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20) |
                 (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
         end
         7: begin ok = imm >= -2048 && imm <= 2047; w = ((u & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h67; end
         8: begin ok = (u & 'hFFF) == 0; w = (u & 32'hFFFFF000) | (rd << 7) | 'h37; end
         default: ok = 1'b0;
      endcase
   endfunction

   task automatic set_req(input int k, input int f3, input int b5, input int rd,
                          input int rs1, input int rs2, input int imm);
      in_kind = 4'(k); in_funct3 = 3'(f3); in_funct7b5 = 1'(b5);
      in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".out_valid"}, out_valid, m_valid);
      chk({tag, ".out_instr"}, out_instr, m_instr);
      chk({tag, ".out_addr"}, out_addr, m_addr);
      chk({tag, ".err"}, err, m_err);
      chk({tag, ".err_cnt"}, err_cnt, m_cnt);
   endtask

   task automatic model_reset();
      m_valid = 0; m_instr = '0; m_addr = '0; m_pc = '0; m_err = 0; m_cnt = 0;
   endtask

   // One clock: drive, check in_ready, advance model at the edge, check outputs after it.
   task automatic cyc(input string tag, input logic c, input logic v, input logic r);
      bit          ok, rdy;
      logic [31:0] w;
      clear = c; in_valid = v; out_ready = r;
      #1;
      rdy = rst_n && !c && (!m_valid || r);
      chk({tag, ".in_ready"}, in_ready, rdy);
      ref_enc(in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, $signed(in_imm), ok, w);
      @(posedge clk);
      if (c) begin
         m_valid = 0; m_pc = '0; m_err = 0; m_cnt = 0;
      end else if (v && rdy && ok) begin
         m_valid = 1; m_instr = w; m_addr = m_pc; m_pc = m_pc + 4;
      end else begin
         if (r) m_valid = 0;
         if (v && rdy) begin m_err = 1; if (m_cnt < 255) m_cnt++; end
      end
      #1;
      check_outs(tag);
   endtask

   function automatic int rnd_imm();
      case ($urandom_range(0, 4))
         0: return int'($urandom_range(0, 40)) - 4;
         1: return int'($urandom_range(0, 8200)) - 4100;
         2: return int'($urandom_range(0, 2 ** 21 + 8)) - (2 ** 20 + 4);
         3: return int'($urandom & 32'hFFFFF000);
         default: return int'($urandom);
      endcase
   endfunction

   initial begin
      #12;
      check_outs("reset");
      chk("reset.in_ready", in_ready, 0);
      #10 rst_n = 1'b1;
      set_req(0, 0, 0, 3, 1, 2, 0);
      cyc("r_add", 0, 1, 1);
      chk("r_add.word", out_instr, 32'h002081B3);
      chk("r_add.addr", out_addr, 32'h0);
      cyc("clr1", 1, 0, 1);
      set_req(3, 0, 0, 0, 2, 5, 8);
      cyc("sw", 0, 1, 1);
      chk("sw.word", out_instr, 32'h00512423);
      chk("sw.addr", out_addr, 32'h0);
      set_req(4, 0, 0, 0, 1, 2, -4);
      cyc("beq", 0, 1, 1);
      chk("beq.word", out_instr, 32'hFE208EE3);
      chk("beq.addr", out_addr, 32'h4);
      cyc("clr2", 1, 0, 1);
      set_req(6, 0, 0, 0, 0, 0, 8);
      cyc("jal", 0, 1, 0);
      chk("jal.word", out_instr, 32'h0080006F);
      set_req(8, 0, 0, 5, 0, 0, 32'h12345000);
      for (int i = 0; i < 3; i++) begin
         cyc("stall", 0, 1, 0);
         chk("stall.in_ready", in_ready, 0);
         chk("stall.word", out_instr, 32'h0080006F);
      end
      cyc("lui", 0, 1, 1);
      chk("lui.word", out_instr, 32'h123452B7);
      chk("lui.addr", out_addr, 32'h4);
      cyc("clr3", 1, 0, 1);
      set_req(4, 0, 0, 0, 1, 2, 3);
      cyc("rej_beq", 0, 1, 1);
      set_req(7, 0, 0, 1, 1, 0, 4096);
      cyc("rej_jalr", 0, 1, 1);
      set_req(12, 0, 0, 1, 1, 1, 0);
      cyc("rej_kind", 0, 1, 1);
      chk("rej.valid", out_valid, 0);
      chk("rej.err", err, 1);
      chk("rej.cnt", err_cnt, 3);
      set_req(0, 0, 1, 4, 5, 6, 0);
      cyc("after_rej", 0, 1, 1);
      chk("after_rej.addr", out_addr, 32'h0);
      set_req(9, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) cyc("sat", 0, 1, 1);
      chk("sat.cnt", err_cnt, 255);
      set_req(1, 0, 0, 2, 3, 0, -2048);
      cyc("pre_clr", 0, 1, 0);
      cyc("clr_busy", 1, 1, 0);
      chk("clr_busy.valid", out_valid, 0);
      chk("clr_busy.err", err, 0);
      cyc("post_clr", 0, 1, 0);
      chk("post_clr.addr", out_addr, 32'h0);
      cyc("mid_stall", 0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outs("async_rst");
      chk("async_rst.in_ready", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 600; i++) begin
         set_req($urandom_range(0, 9) == 0 ? $urandom_range(9, 15) : $urandom_range(0, 8),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), rnd_imm());
         cyc("rand", $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
